// File: rtl/membus_arbiter_if.sv
// rtl/membus_arbiter_if.sv - request/response bundle between the I/D masters, the arbiter and the downstream membus
interface membus_arbiter_if #(
  parameter int XLEN       = 64,
  parameter int ILEN       = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                    i_valid;
  logic                    i_ready;
  logic [XLEN-1:0]         i_addr;
  logic                    i_rvalid;
  logic [ILEN-1:0]         i_rdata;

  logic                    d_valid;
  logic                    d_ready;
  logic [XLEN-1:0]         d_addr;
  logic                    d_wen;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH/8-1:0] d_wmask;
  logic                    d_rvalid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  logic                    m_valid;
  logic                    m_ready;
  logic [XLEN-1:0]         m_addr;
  logic                    m_wen;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wmask;
  logic                    m_rvalid;
  logic [DATA_WIDTH-1:0]   m_rdata;

  logic [CW-1:0]           outstanding;
  logic                    err;

  // arbiter view
  modport slave (
    input  i_valid, i_addr,
    input  d_valid, d_addr, d_wen, d_wdata, d_wmask,
    input  m_ready, m_rvalid, m_rdata,
    output i_ready, i_rvalid, i_rdata,
    output d_ready, d_rvalid, d_rdata,
    output m_valid, m_addr, m_wen, m_wdata, m_wmask,
    output outstanding, err
  );

  // environment view: both masters plus the downstream responder
  modport master (
    output i_valid, i_addr,
    output d_valid, d_addr, d_wen, d_wdata, d_wmask,
    output m_ready, m_rvalid, m_rdata,
    input  i_ready, i_rvalid, i_rdata,
    input  d_ready, d_rvalid, d_rdata,
    input  m_valid, m_addr, m_wen, m_wdata, m_wmask,
    input  outstanding, err
  );
endinterface

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - I/D membus arbiter with starvation guard and in-order response tag FIFO
module membus_arbiter #(
  parameter int XLEN         = 64,
  parameter int ILEN         = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  membus_arbiter_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);
  localparam logic [PW-1:0] LAST_C   = PW'(DEPTH - 1);

  // tag = {src, addr[2]}; src 1 = I, 0 = D
  logic [1:0]    tag_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          err_q, err_d;

  logic          fifo_empty;
  logic          space;
  logic          force_i;
  logic          gnt_d;
  logic          gnt_i;
  logic          req_ok;
  logic          push;
  logic          pop;
  logic [1:0]    head;
  logic [XLEN-1:0] sel_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Grant and handshake decode; a same-cycle pop frees a slot so a full FIFO still accepts
  always_comb begin
    fifo_empty = (count_q == '0);
    space      = (count_q < DEPTH_C) | bus.m_rvalid;
    force_i    = bus.i_valid & (streak_q == STARVE_C);
    gnt_d      = bus.d_valid & ~force_i;
    gnt_i      = bus.i_valid & ~gnt_d;
    req_ok     = rst & space & (gnt_i | gnt_d);
    push       = req_ok & bus.m_ready;
    pop        = rst & bus.m_rvalid & ~fifo_empty;
    sel_addr   = gnt_i ? bus.i_addr : bus.d_addr;
    head       = tag_q[rd_ptr_q];
  end

  // Downstream request mux and response routing to the issuing master
  always_comb begin
    bus.m_valid     = req_ok;
    bus.d_ready     = push & gnt_d;
    bus.i_ready     = push & gnt_i;
    bus.m_addr      = sel_addr;
    bus.m_wen       = gnt_d & bus.d_wen;
    bus.m_wdata     = gnt_d ? bus.d_wdata : '0;
    bus.m_wmask     = gnt_d ? bus.d_wmask : '0;
    bus.i_rvalid    = pop & head[1];
    bus.d_rvalid    = pop & ~head[1];
    bus.d_rdata     = bus.m_rdata;
    bus.outstanding = count_q;
    bus.err         = err_q;
  end

  // Instruction word lane select: addr[2] picks the upper half of a 64-bit beat
  if (DATA_WIDTH == 64) begin : g_rdata64
    assign bus.i_rdata = head[0] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
  end else begin : g_rdata32
    assign bus.i_rdata = bus.m_rdata[31:0];
  end

  // Next-state for FIFO pointers, occupancy, starvation streak and sticky error
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    streak_d = streak_q;
    if (!bus.i_valid || (push && gnt_i)) begin
      streak_d = '0;
    end else if (push && gnt_d) begin
      streak_d = (streak_q == STARVE_C) ? streak_q : streak_q + 1'b1;
    end
    err_d = err_q | (bus.m_rvalid & fifo_empty);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  // Tag storage written on every accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= 2'b00;
      end
    end else if (push) begin
      tag_q[wr_ptr_q] <= {gnt_i, sel_addr[2]};
    end
  end
endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - directed vector bench for membus_arbiter
module tb_membus_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   passed;

  membus_arbiter_if #(.XLEN(64), .ILEN(32), .DATA_WIDTH(64), .DEPTH(2)) bus ();

  membus_arbiter #(
    .XLEN(64), .ILEN(32), .DATA_WIDTH(64), .DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic        dw;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic        mr;
    logic        mrv;
    logic [63:0] mrd;
    logic        e_ir;
    logic        e_dr;
    logic        e_mv;
    logic [63:0] e_ma;
    logic        e_mw;
    logic [63:0] e_mwd;
    logic [7:0]  e_mwm;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [1:0]  e_out;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid  = 1'b0;
    bus.i_addr   = '0;
    bus.d_valid  = 1'b0;
    bus.d_addr   = '0;
    bus.d_wen    = 1'b0;
    bus.d_wdata  = '0;
    bus.d_wmask  = '0;
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  localparam logic [63:0] A = 64'hAAAA_BBBB_CCCC_DDDD;

  initial begin
    total  = 0;
    passed = 0;

    vec[0]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b0, 2'd0};
    vec[1]  = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 64'h0,
                1'b1, 1'b0, 1'b1, 64'h8000_0004, 1'b0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b0, 2'd0};
    vec[2]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b1, A,
                1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b1, 32'hAAAA_BBBB, 1'b0, 2'd1};
    vec[3]  = '{1'b0, 64'h0, 1'b1, 64'h100, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 1'b0, 64'h0,
                1'b0, 1'b1, 1'b1, 64'h100, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 32'h0, 1'b0, 2'd0};
    vec[4]  = '{1'b0, 64'h0, 1'b1, 64'h208, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b0, 1'b1, 64'h208, 1'b0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b0, 2'd1};
    vec[5]  = '{1'b1, 64'h10, 1'b1, 64'h208, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 64'h0,
                1'b0, 1'b1, 1'b1, 64'h208, 1'b0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b0, 2'd1};
    vec[6]  = '{1'b1, 64'h10, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b1, 1'b0, 64'h0,
                1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b0, 2'd2};
    vec[7]  = '{1'b1, 64'h10, 1'b0, 64'h0, 1'b0, 64'hDEAD, 8'hF0, 1'b1, 1'b1, 64'h55,
                1'b1, 1'b0, 1'b1, 64'h10, 1'b0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b1, 2'd2};
    vec[8]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b1, A,
                1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b1, 2'd2};
    vec[9]  = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b1, A,
                1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b1, 32'hCCCC_DDDD, 1'b0, 2'd1};
    vec[10] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h0, 1'b0, 32'h0, 1'b0, 2'd0};

    // reset state, with requests pending to show readys stay low
    rst = 1'b0;
    idle();
    bus.i_valid = 1'b1;
    bus.d_valid = 1'b1;
    bus.m_ready = 1'b1;
    repeat (2) tick();
    #3;
    chk("rst i_ready", 64'(bus.i_ready), 64'd0);
    chk("rst d_ready", 64'(bus.d_ready), 64'd0);
    chk("rst outstanding", 64'(bus.outstanding), 64'd0);
    chk("rst err", 64'(bus.err), 64'd0);
    chk("rst rvalids", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
    tick();
    idle();
    rst = 1'b1;
    tick();

    // directed vector table, one cycle per entry
    for (int i = 0; i < 11; i++) begin
      bus.i_valid  = vec[i].iv;
      bus.i_addr   = vec[i].ia;
      bus.d_valid  = vec[i].dv;
      bus.d_addr   = vec[i].da;
      bus.d_wen    = vec[i].dw;
      bus.d_wdata  = vec[i].wd;
      bus.d_wmask  = vec[i].wm;
      bus.m_ready  = vec[i].mr;
      bus.m_rvalid = vec[i].mrv;
      bus.m_rdata  = vec[i].mrd;
      #3;
      chk($sformatf("v%0d i_ready", i), 64'(bus.i_ready), 64'(vec[i].e_ir));
      chk($sformatf("v%0d d_ready", i), 64'(bus.d_ready), 64'(vec[i].e_dr));
      chk($sformatf("v%0d m_valid", i), 64'(bus.m_valid), 64'(vec[i].e_mv));
      if (vec[i].e_mv) begin
        chk($sformatf("v%0d m_addr", i), bus.m_addr, vec[i].e_ma);
        chk($sformatf("v%0d m_wen", i), 64'(bus.m_wen), 64'(vec[i].e_mw));
        chk($sformatf("v%0d m_wdata", i), bus.m_wdata, vec[i].e_mwd);
        chk($sformatf("v%0d m_wmask", i), 64'(bus.m_wmask), 64'(vec[i].e_mwm));
      end
      chk($sformatf("v%0d i_rvalid", i), 64'(bus.i_rvalid), 64'(vec[i].e_irv));
      if (vec[i].e_irv) begin
        chk($sformatf("v%0d i_rdata", i), 64'(bus.i_rdata), 64'(vec[i].e_ird));
      end
      chk($sformatf("v%0d d_rvalid", i), 64'(bus.d_rvalid), 64'(vec[i].e_drv));
      if (vec[i].e_drv) begin
        chk($sformatf("v%0d d_rdata", i), bus.d_rdata, vec[i].mrd);
      end
      chk($sformatf("v%0d outstanding", i), 64'(bus.outstanding), 64'(vec[i].e_out));
      chk($sformatf("v%0d err", i), 64'(bus.err), 64'd0);
      tick();
    end

    // starvation guard: both masters always requesting -> D,D,D,D,I repeating
    idle();
    for (int k = 0; k < 10; k++) begin
      bus.i_valid  = 1'b1;
      bus.i_addr   = 64'h40;
      bus.d_valid  = 1'b1;
      bus.d_addr   = 64'h80;
      bus.m_ready  = 1'b1;
      bus.m_rvalid = (k > 0);
      bus.m_rdata  = 64'(k);
      #3;
      chk($sformatf("st%0d i_ready", k), 64'(bus.i_ready), 64'((k % 5) == 4));
      chk($sformatf("st%0d d_ready", k), 64'(bus.d_ready), 64'((k % 5) != 4));
      chk($sformatf("st%0d m_addr", k), bus.m_addr, ((k % 5) == 4) ? 64'h40 : 64'h80);
      chk($sformatf("st%0d i_rvalid", k), 64'(bus.i_rvalid), 64'((k > 0) && ((k - 1) % 5) == 4));
      chk($sformatf("st%0d d_rvalid", k), 64'(bus.d_rvalid), 64'((k > 0) && ((k - 1) % 5) != 4));
      tick();
    end
    idle();
    bus.m_rvalid = 1'b1;
    #3;
    chk("st drain i_rvalid", 64'(bus.i_rvalid), 64'd1);
    tick();
    bus.m_rvalid = 1'b0;
    #3;
    chk("st drained outstanding", 64'(bus.outstanding), 64'd0);
    chk("st err", 64'(bus.err), 64'd0);
    tick();

    // response with nothing outstanding: dropped and sticky err
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = A;
    #3;
    chk("orphan i_rvalid", 64'(bus.i_rvalid), 64'd0);
    chk("orphan d_rvalid", 64'(bus.d_rvalid), 64'd0);
    tick();
    bus.m_rvalid = 1'b0;
    #3;
    chk("orphan err set", 64'(bus.err), 64'd1);
    repeat (3) tick();
    #3;
    chk("orphan err sticky", 64'(bus.err), 64'd1);
    tick();

    // reset mid-operation discards tags; the late response then flags err
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h4;
    bus.m_ready = 1'b1;
    #3;
    chk("mid i_ready", 64'(bus.i_ready), 64'd1);
    tick();
    idle();
    #1;
    rst = 1'b0;
    #1;
    chk("mid rst outstanding", 64'(bus.outstanding), 64'd0);
    chk("mid rst err", 64'(bus.err), 64'd0);
    tick();
    rst = 1'b1;
    bus.m_rvalid = 1'b1;
    #3;
    chk("late i_rvalid", 64'(bus.i_rvalid), 64'd0);
    chk("late d_rvalid", 64'(bus.d_rvalid), 64'd0);
    tick();
    bus.m_rvalid = 1'b0;
    #3;
    chk("late err", 64'(bus.err), 64'd1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
